sort_mem_host: RTL and testbench
================================

Name: sort_mem_host

Overview:
- Memory-side responder and host bridge for the bubble-sort controller/datapath.
- Owns the DEPTH-word data memory the sorter reads and writes.
- Loads the unsorted array from a host valid/ready stream, then pulses the sorter's start and waits for it to finish.
- Streams the sorted array back out over a second valid/ready stream.

Parameters:
- DEPTH, 8, number of words in memory (power of two, ≥2).
- AW, 3, address width, equal to log2(DEPTH).
- DW, 8, data word width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- read_mem  in  1  sorter read request.
- write_mem  in  1  sorter write request.
- addr  in  AW  sorter word address.
- wdata  in  DW  sorter write data.
- rdata  out  DW  read data to sorter.
- sort_start  out  1  start to sorter controller.
- sort_done  in  1  sorter done/idle flag (1 while sorter idle).
- in_valid  in  1  host input word valid.
- in_data  in  DW  host input word.
- in_ready  out  1  block accepts input word.
- out_valid  out  1  output word valid.
- out_data  out  DW  output word.
- out_ready  in  1  host accepts output word.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (rst=0, async):
  - state=LOAD, ptr=0.
  - All memory words cleared to 0.
  - sort_start=0, out_valid=0, busy=0, in_ready=1.
- ptr is an AW-bit word pointer shared by the LOAD and DUMP phases.
- States: LOAD, KICK, WAIT_BUSY, WAIT_DONE, DUMP.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem[ptr]<=in_data, ptr++.
  - When the word at ptr=DEPTH-1 is accepted: ptr wraps to 0, go to KICK.
  - Fewer than DEPTH words accepted: stay in LOAD indefinitely.
- KICK:
  - sort_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - sort_start is a registered output.
- WAIT_BUSY: stay until sort_done=0, then go to WAIT_DONE.
- WAIT_DONE: stay until sort_done=1, then go to DUMP with ptr=0.
- Sorter port:
  - Serviced only in WAIT_BUSY and WAIT_DONE; ignored in all other states.
  - rdata = mem[addr] combinationally, same cycle, so the sorter's register loads on the same edge. rdata is driven in all states.
  - write_mem=1 at a rising edge: mem[addr]<=wdata.
  - read_mem and write_mem both high: rdata shows the old word; the write lands at the edge.
- DUMP:
  - out_valid=1, out_data=mem[ptr] (combinational from ptr).
  - On out_valid&out_ready: ptr++.
  - After the transfer at ptr=DEPTH-1: ptr=0, return to LOAD.
  - out_ready low holds out_data stable.
- in_ready=0 and in_valid is ignored outside LOAD.
- out_valid=0 outside DUMP.
- Reset mid-operation (any state): full reset values apply, memory cleared, and any in-flight sort result is discarded. The sorter is reset separately by its own owner.
- Throughput: one word per cycle in LOAD and DUMP when the host handshake is continuously asserted.

Test Plan:
- Load 8 words 7,6,5,4,3,2,1,0 back-to-back → in_ready high 8 cycles, then sort_start high exactly 1 cycle, busy=1.
- Behavioural sorter model drops sort_done, performs swaps via read_mem/write_mem, raises sort_done → DUMP emits 0,1,2,...,7 with out_ready=1, then in_ready=1 again.
- Dump with out_ready toggled 1,0,0,1,... → each word held stable while out_ready=0, no word skipped or duplicated.
- write_mem=1, addr=2, wdata=0xAA during LOAD → mem[2] unchanged; same write in WAIT_DONE → rdata=0xAA on the next read of addr 2.
- read_mem=1 and write_mem=1 on the same addr/cycle with old value 0x05, wdata=0x33 → rdata=0x05 that cycle, 0x33 the next cycle.
- Assert rst=0 mid-DUMP after 3 words → out_valid=0, busy=0, in_ready=1 asynchronously; a subsequent dump after a fresh load starts at word 0.

Source files
------------

// File: rtl/sort_mem_host.sv
// sort_mem_host: data memory and host bridge for the bubble-sort engine.
// The host streams DEPTH words in, the sorter gets a one-cycle start pulse
// and works directly on the memory, and the sorted words are then streamed
// back out to the host.
//
// state     | meaning
// ----------+-----------------------------------------------------
// LOAD      | accept host words into mem[ptr]; sorter port ignored
// KICK      | sort_start high for this single cycle
// WAIT_BUSY | wait for the sorter to drop sort_done
// WAIT_DONE | sorter owns memory until sort_done returns high
// DUMP      | present mem[ptr] to the host, advance on handshake
module sort_mem_host #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read_mem,
  input  logic          write_mem,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          sort_start,
  input  logic          sort_done,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    KICK      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DUMP      = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          load_fire, dump_fire, ptr_last, sorter_owns;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Reads are purely combinational from addr, so the read strobe carries
  // no information the memory needs.
  logic          read_unused;
  assign read_unused = read_mem;

  assign load_fire   = (state == LOAD) && in_valid;
  assign dump_fire   = (state == DUMP) && out_ready;
  assign ptr_last    = (ptr == AW'(DEPTH - 1));
  assign sorter_owns = (state == WAIT_BUSY) || (state == WAIT_DONE);

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DUMP);
  assign busy      = (state != LOAD);
  assign rdata     = mem[addr];
  assign out_data  = mem[ptr];

  // Next-state logic; KICK always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:      if (load_fire && ptr_last) state_next = KICK;
      KICK:      state_next = WAIT_BUSY;
      WAIT_BUSY: if (!sort_done) state_next = WAIT_DONE;
      WAIT_DONE: if (sort_done) state_next = DUMP;
      DUMP:      if (dump_fire && ptr_last) state_next = LOAD;
      default:   state_next = LOAD;
    endcase
  end

  // Single memory write port, shared between host load and sorter.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (load_fire) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = in_data;
    end else if (sorter_owns && write_mem) begin
      mem_we = 1'b1;
    end
  end

  // State register; sort_start is registered off the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      sort_start <= 1'b0;
    end else begin
      state      <= state_next;
      sort_start <= (state_next == KICK);
    end
  end

  // Word pointer shared by load and dump; wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load_fire || dump_fire) begin
      ptr <= ptr + 1'b1;
    end else if ((state == WAIT_DONE) && sort_done) begin
      ptr <= '0;
    end
  end

  // Data memory; cleared on reset so a discarded sort leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_sort_mem_host.sv
// tb_sort_mem_host: directed bench with a behavioural bubble sorter that
// drives the memory port, plus host load/dump stimulus.
module tb_sort_mem_host;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_mem = 1'b0;
  logic          write_mem = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          sort_start;
  logic          sort_done = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  sort_mem_host #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .sort_start (sort_start),
    .sort_done  (sort_done),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams 8 words (word k = v[8k+:8]) back to back; returns in KICK.
  task automatic load_words(input logic [63:0] v);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[8*k +: 8];
      #1 check("load_in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("kick_sort_start", 32'(sort_start), 32'd1);
    check("kick_busy", 32'(busy), 32'd1);
    check("kick_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Behavioural sorter: handshake on sort_done, bubble sort through the port.
  task automatic run_sort(input bit port_tests);
    logic [DW-1:0] a, b;
    sort_done = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    @(negedge clk);
    #1;
    check("start_one_cycle", 32'(sort_start), 32'd0);
    check("wait_busy_in_ready", 32'(in_ready), 32'd0);
    check("wait_busy_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    if (port_tests) begin
      read_mem = 1'b1; write_mem = 1'b1; addr = 3'd2; wdata = 8'h33;
      #1 check("rw_same_cycle_old", 32'(rdata), 32'h05);
      @(negedge clk);
      write_mem = 1'b0;
      #1 check("rw_next_cycle_new", 32'(rdata), 32'h33);
      write_mem = 1'b1; wdata = 8'hAA;
      @(negedge clk);
      write_mem = 1'b0;
      #1 check("wait_done_write", 32'(rdata), 32'hAA);
      write_mem = 1'b1; wdata = 8'h05;
      @(negedge clk);
      write_mem = 1'b0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      for (int j = 0; j < DEPTH - 1 - i; j++) begin
        @(negedge clk);
        write_mem = 1'b0;
        read_mem  = 1'b1;
        addr = AW'(j);
        #1 a = rdata;
        addr = AW'(j + 1);
        #1 b = rdata;
        if (a > b) begin
          @(negedge clk);
          read_mem = 1'b0; write_mem = 1'b1; addr = AW'(j); wdata = b;
          @(negedge clk);
          addr = AW'(j + 1); wdata = a;
        end
      end
    end
    @(negedge clk);
    read_mem  = 1'b0;
    write_mem = 1'b0;
    sort_done = 1'b1;
    @(negedge clk);
    #1 check("dump_entry_valid", 32'(out_valid), 32'd1);
  endtask

  // Drains nwords from DUMP; toggle uses out_ready pattern 1,0,0,1 repeating.
  task automatic dump_check(input logic [63:0] exp, input bit toggle, input int nwords);
    int k = 0;
    int c = 0;
    while (k < nwords && c < 64) begin
      @(negedge clk);
      out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      check("dump_valid", 32'(out_valid), 32'd1);
      check($sformatf("dump_data[%0d]", k), 32'(out_data), 32'(exp[8*k +: 8]));
      if (out_ready) k++;
      c++;
    end
    if (k < nwords) check("dump_timeout", 32'(k), 32'(nwords));
  endtask

  task automatic check_back_in_load(input string tag);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sort_start", 32'(sort_start), 32'd0);
    check("rst_mem0", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Sorter write ignored while loading.
    @(negedge clk);
    write_mem = 1'b1; addr = 3'd2; wdata = 8'hAA;
    @(negedge clk);
    write_mem = 1'b0;
    #1 check("load_write_ignored", 32'(rdata), 32'd0);

    // Run 1: 7..0 in, 0..7 out with continuous out_ready.
    load_words(64'h0001020304050607);
    run_sort(1'b1);
    dump_check(64'h0706050403020100, 1'b0, DEPTH);
    check_back_in_load("run1_done");

    // Run 2: mixed data, out_ready toggled 1,0,0,1.
    load_words(64'h02070740C8010903);
    run_sort(1'b0);
    dump_check(64'hC840090707030201, 1'b1, DEPTH);
    check_back_in_load("run2_done");

    // Run 3: reset after three words of the dump.
    load_words(64'h1011121314151617);
    run_sort(1'b0);
    dump_check(64'h1716151413121110, 1'b0, 3);
    @(negedge clk);
    out_ready = 1'b0;
    #1 check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    addr = 3'd0;
    #1 check("mid_rst_mem_cleared", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Run 4: fresh load after reset dumps from word 0.
    load_words(64'h5756555453525150);
    run_sort(1'b0);
    dump_check(64'h5756555453525150, 1'b0, DEPTH);
    check_back_in_load("run4_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
